// File: rtl/picomips_io_sequencer.sv
// Front-panel I/O sequencer: debounces Bstus, captures NIN operands from SW, hands them
// to the picoMIPS core over valid/ready, then steps NOUT results onto LED one press at a time.
module picomips_io_sequencer #(
    parameter int DW          = 8,
    parameter int NIN         = 2,
    parameter int NOUT        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                 fastclk,
    input  logic                 nreset,
    input  logic                 Bstus,
    input  logic [DW-1:0]        SW,
    output logic [DW-1:0]        LED,
    output logic [NIN*DW-1:0]    in_data,
    output logic                 in_valid,
    input  logic                 in_ready,
    input  logic [NOUT*DW-1:0]   res_data,
    input  logic                 res_valid,
    output logic                 res_ready,
    output logic [1:0]           phase
);

    typedef enum logic [1:0] {
        PH_CAPTURE  = 2'd0,
        PH_ISSUE    = 2'd1,
        PH_WAIT_RES = 2'd2,
        PH_SHOW     = 2'd3
    } phase_t;

    localparam int MAXN = (NIN > NOUT) ? NIN : NOUT;
    localparam int IW   = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam int CW   = $clog2(DEBOUNCE + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   armed_q, armed_d;
    phase_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DW-1:0]          led_q, led_d;
    logic [NIN*DW-1:0]      in_data_q, in_data_d;
    logic                   in_valid_q, in_valid_d;
    logic [NOUT*DW-1:0]     res_q, res_d;
    logic                   res_ready_q, res_ready_d;
    logic                   synced;
    logic                   press;

    always_ff @(posedge fastclk or negedge nreset) begin
        if (!nreset) begin
            // Sync chain and debounced level start high so a held switch never looks like an edge
            sync_q      <= '1;
            cnt_q       <= '0;
            deb_q       <= 1'b1;
            armed_q     <= 1'b0;
            state_q     <= PH_CAPTURE;
            idx_q       <= '0;
            led_q       <= '0;
            in_data_q   <= '0;
            in_valid_q  <= 1'b0;
            res_q       <= '0;
            res_ready_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            deb_q       <= deb_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            led_q       <= led_d;
            in_data_q   <= in_data_d;
            in_valid_q  <= in_valid_d;
            res_q       <= res_d;
            res_ready_q <= res_ready_d;
        end
    end

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], Bstus};
        synced      = sync_q[SYNC_STAGES-1];
        cnt_d       = '0;
        deb_d       = deb_q;
        armed_d     = armed_q;
        state_d     = state_q;
        idx_d       = idx_q;
        led_d       = led_q;
        in_data_d   = in_data_q;
        in_valid_d  = in_valid_q;
        res_d       = res_q;
        res_ready_d = 1'b0;

        // Count consecutive cycles the synced level disagrees with the debounced one
        if (synced != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE - 1)) begin
                deb_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // armed only sets while debounced is low, so debounced high with armed set is a fresh rise
        press = deb_q & armed_q;
        if (press) begin
            armed_d = 1'b0;
        end else if (!deb_q) begin
            armed_d = 1'b1;
        end

        case (state_q)
            PH_CAPTURE: begin
                if (press) begin
                    in_data_d[int'(idx_q)*DW +: DW] = SW;
                    led_d = SW;
                    if (idx_q == IW'(NIN - 1)) begin
                        idx_d      = '0;
                        in_valid_d = 1'b1;
                        state_d    = PH_ISSUE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            PH_ISSUE: begin
                if (in_valid_q && in_ready) begin
                    in_valid_d = 1'b0;
                    state_d    = PH_WAIT_RES;
                end
            end
            PH_WAIT_RES: begin
                if (res_valid) begin
                    res_d       = res_data;
                    res_ready_d = 1'b1;
                    led_d       = res_data[DW-1:0];
                    idx_d       = '0;
                    state_d     = PH_SHOW;
                end
            end
            PH_SHOW: begin
                if (press) begin
                    if (idx_q == IW'(NOUT - 1)) begin
                        led_d   = '0;
                        idx_d   = '0;
                        state_d = PH_CAPTURE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        led_d = res_q[int'(idx_d)*DW +: DW];
                    end
                end
            end
            default: state_d = PH_CAPTURE;
        endcase
    end

    assign LED       = led_q;
    assign in_data   = in_data_q;
    assign in_valid  = in_valid_q;
    assign res_ready = res_ready_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_picomips_io_sequencer.sv
// Scoreboard bench for picomips_io_sequencer: stimulus queues expected LED / operand / result
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_picomips_io_sequencer;
    localparam int DW = 8, NIN = 2, NOUT = 2;

    logic               fastclk = 1'b0;
    logic               nreset  = 1'b0;
    logic               Bstus   = 1'b1;
    logic [DW-1:0]      SW      = '0;
    logic [DW-1:0]      LED;
    logic [NIN*DW-1:0]  in_data;
    logic               in_valid;
    logic               in_ready = 1'b0;
    logic [NOUT*DW-1:0] res_data = '0;
    logic               res_valid = 1'b0;
    logic               res_ready;
    logic [1:0]         phase;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]     led_exp_q[$];
    logic [NIN*DW-1:0] iv_exp_q[$];
    logic [DW-1:0]     rr_exp_q[$];

    picomips_io_sequencer #(.DW(DW), .NIN(NIN), .NOUT(NOUT), .SYNC_STAGES(2), .DEBOUNCE(4)) dut (
        .fastclk(fastclk), .nreset(nreset), .Bstus(Bstus), .SW(SW), .LED(LED),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .phase(phase)
    );

    always #10 fastclk = ~fastclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge fastclk);
        #1;
    endtask

    task automatic press(input logic [DW-1:0] v);
        Bstus = 1'b0;
        wait_cyc(10);
        SW    = v;
        Bstus = 1'b1;
        wait_cyc(10);
    endtask

    // Monitor: compares every LED change, operand offer and result acceptance against the queues
    logic [DW-1:0] led_prev = '0;
    logic          iv_prev  = 1'b0;
    logic          rr_prev  = 1'b0;
    always @(negedge fastclk) begin
        if (LED !== led_prev) begin
            if (led_exp_q.size() == 0) check("led_unexpected", 32'(LED), 32'(led_prev));
            else check("led", 32'(LED), 32'(led_exp_q.pop_front()));
        end
        if (in_valid && !iv_prev) begin
            if (iv_exp_q.size() == 0) check("in_valid_unexpected", 32'(in_valid), 32'd0);
            else check("in_data", 32'(in_data), 32'(iv_exp_q.pop_front()));
        end
        if (res_ready) begin
            if (rr_prev) check("res_ready_width", 32'd2, 32'd1);
            else if (rr_exp_q.size() == 0) check("res_ready_unexpected", 32'(res_ready), 32'd0);
            else check("res_led", 32'(LED), 32'(rr_exp_q.pop_front()));
        end
        led_prev <= LED;
        iv_prev  <= in_valid;
        rr_prev  <= res_ready;
    end

    initial begin
        // 1: reset, Bstus held high -> nothing captured
        wait_cyc(3);
        nreset = 1'b1;
        wait_cyc(20);
        check("rst_led", 32'(LED), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_in_valid", 32'(in_valid), 32'd0);
        check("rst_in_data", 32'(in_data), 32'd0);
        check("rst_res_ready", 32'(res_ready), 32'd0);

        led_exp_q.push_back(8'h04);
        press(8'h04);

        // 3: 2-cycle glitch must be ignored
        Bstus = 1'b0;
        wait_cyc(10);
        SW    = 8'h55;
        Bstus = 1'b1;
        wait_cyc(2);
        Bstus = 1'b0;
        wait_cyc(10);
        check("glitch_phase", 32'(phase), 32'd0);
        check("glitch_led", 32'(LED), 32'h04);

        // 2: second press, in_valid exactly 7 cycles after raw rise
        led_exp_q.push_back(8'h08);
        iv_exp_q.push_back(16'h0804);
        SW    = 8'h08;
        Bstus = 1'b1;
        wait_cyc(6);
        check("iv_at_6", 32'(in_valid), 32'd0);
        wait_cyc(1);
        check("iv_at_7", 32'(in_valid), 32'd1);
        check("phase_issue", 32'(phase), 32'd1);

        // 4: stall 5 cycles with SW wiggling
        for (int i = 0; i < 5; i++) begin
            SW = 8'(8'hA0 + i);
            wait_cyc(1);
            check("stall_valid", 32'(in_valid), 32'd1);
            check("stall_data", 32'(in_data), 32'h0804);
        end
        in_ready = 1'b1;
        wait_cyc(1);
        in_ready = 1'b0;
        check("hs_valid_drop", 32'(in_valid), 32'd0);
        check("phase_wait", 32'(phase), 32'd2);

        // 5: results
        led_exp_q.push_back(8'h02);
        rr_exp_q.push_back(8'h02);
        res_data  = 16'h0C02;
        res_valid = 1'b1;
        wait_cyc(3);
        res_valid = 1'b0;
        check("phase_show", 32'(phase), 32'd3);
        led_exp_q.push_back(8'h0C);
        press(8'h99);
        led_exp_q.push_back(8'h00);
        press(8'h99);
        check("phase_back", 32'(phase), 32'd0);

        // 6: press in WAIT_RES, then reset
        led_exp_q.push_back(8'h11);
        press(8'h11);
        led_exp_q.push_back(8'h22);
        iv_exp_q.push_back(16'h2211);
        press(8'h22);
        in_ready = 1'b1;
        wait_cyc(1);
        in_ready = 1'b0;
        press(8'h77);
        check("wait_press_phase", 32'(phase), 32'd2);
        check("wait_press_led", 32'(LED), 32'h22);
        led_exp_q.push_back(8'h00);
        nreset = 1'b0;
        #1;
        check("mid_rst_led", 32'(LED), 32'd0);
        check("mid_rst_in_data", 32'(in_data), 32'd0);
        check("mid_rst_in_valid", 32'(in_valid), 32'd0);
        check("mid_rst_res_ready", 32'(res_ready), 32'd0);
        check("mid_rst_phase", 32'(phase), 32'd0);
        wait_cyc(1);
        nreset = 1'b1;
        wait_cyc(5);
        led_exp_q.push_back(8'h33);
        press(8'h33);
        led_exp_q.push_back(8'h44);
        iv_exp_q.push_back(16'h4433);
        press(8'h44);
        check("post_rst_phase", 32'(phase), 32'd1);
        wait_cyc(3);

        check("led_queue_empty", 32'(led_exp_q.size()), 32'd0);
        check("iv_queue_empty", 32'(iv_exp_q.size()), 32'd0);
        check("rr_queue_empty", 32'(rr_exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
